// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_pkg
// Description : Shared pipeline-control definitions: FSM encoding, register
//               specifier width and the pipeline-control bundle layout.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

    localparam int c_REG_ADDR_W = 5;

    localparam int         c_STATE_W     = 2;
    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_LOAD_USE = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

    // Field order is shared with the forwarding logic; keep it stable.
    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic ifIdFlush;
        logic idExFlush;
        logic exMemStall;
    } pipeCtrl_t;

    localparam int c_PIPE_CTRL_W = $bits(pipeCtrl_t);

    localparam pipeCtrl_t c_CTRL_IDLE       = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipeCtrl_t c_CTRL_RESET      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pipeCtrl_t c_CTRL_MEM_STALL  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipeCtrl_t c_CTRL_BRANCH     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipeCtrl_t c_CTRL_LOAD_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage : hazard_stall_unit_pkg
`default_nettype wire

// File: rtl/hazard_stall_unit_stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : stall_counter
// Description : Saturating event counter with enable and synchronous
//               active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clearN,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_atMax;

    assign w_atMax = &r_count;

    always_ff @(posedge clk) begin
        if (!i_clearN) begin
            r_count <= '0;
        end else if (i_en && !w_atMax) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : stall_counter
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline hazard controller for load-use bubbles, data-memory
//               wait states and taken-branch flushes (Mealy outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = c_REG_ADDR_W,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [REG_ADDR_W-1:0] ifIdRs,
    input  logic [REG_ADDR_W-1:0] ifIdRt,
    input  logic                  ifIdUsesRt,
    input  logic [REG_ADDR_W-1:0] idExRt,
    input  logic                  idExMemRead,
    input  logic                  exMemMemRead,
    input  logic                  exMemMemWrite,
    input  logic                  memReady,
    input  logic                  branchTaken,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  ifIdFlush,
    output logic                  idExFlush,
    output logic                  exMemStall,
    output logic [CNT_W-1:0]      stallCount
);

    localparam logic [1:0] c_BUBBLE_INIT = 2'(LOAD_LATENCY - 1);

    logic [c_STATE_W-1:0]  r_state;
    logic                  r_retLoadUse;
    logic [1:0]            r_bubbleCnt;
    logic [REG_ADDR_W-1:0] r_pendRd;

    logic [c_STATE_W-1:0]  w_effState;
    logic                  w_memBusy;
    logic                  w_loadHit;
    logic                  w_pendHit;
    pipeCtrl_t             w_ctrl;

    assign w_memBusy = (exMemMemRead | exMemMemWrite) & ~memReady;

    assign w_loadHit = idExMemRead && (idExRt != '0) &&
                       ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

    assign w_pendHit = (r_pendRd != '0) &&
                       ((r_pendRd == ifIdRs) || (ifIdUsesRt && (r_pendRd == ifIdRt)));

    // Once memory is no longer busy, MEM_WAIT behaves as the state it froze.
    always_comb begin
        w_effState = r_state;
        if (r_state == c_ST_MEM_WAIT) begin
            w_effState = r_retLoadUse ? c_ST_LOAD_USE : c_ST_RUN;
        end else if (r_state != c_ST_LOAD_USE) begin
            w_effState = c_ST_RUN;
        end
    end

    always_comb begin
        w_ctrl = c_CTRL_IDLE;
        if (!resetN) begin
            w_ctrl = c_CTRL_RESET;
        end else if (w_memBusy) begin
            w_ctrl = c_CTRL_MEM_STALL;
        end else if (branchTaken) begin
            w_ctrl = c_CTRL_BRANCH;
        end else if ((w_effState == c_ST_RUN) && w_loadHit) begin
            w_ctrl = c_CTRL_LOAD_STALL;
        end else if ((w_effState == c_ST_LOAD_USE) && w_pendHit) begin
            w_ctrl = c_CTRL_LOAD_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state      <= c_ST_RUN;
            r_retLoadUse <= 1'b0;
            r_bubbleCnt  <= 2'd0;
            r_pendRd     <= '0;
        end else if (w_memBusy) begin
            r_state      <= c_ST_MEM_WAIT;
            r_retLoadUse <= (w_effState == c_ST_LOAD_USE);
        end else if (branchTaken) begin
            r_state      <= c_ST_RUN;
            r_retLoadUse <= 1'b0;
            r_bubbleCnt  <= 2'd0;
            r_pendRd     <= '0;
        end else begin
            r_retLoadUse <= 1'b0;
            if (w_effState == c_ST_LOAD_USE) begin
                if (w_pendHit && (r_bubbleCnt > 2'd1)) begin
                    r_state     <= c_ST_LOAD_USE;
                    r_bubbleCnt <= r_bubbleCnt - 2'd1;
                end else begin
                    // Last bubble served, or the dependent instruction left ID.
                    r_state     <= c_ST_RUN;
                    r_bubbleCnt <= 2'd0;
                    r_pendRd    <= '0;
                end
            end else begin
                r_state <= c_ST_RUN;
                if (w_loadHit) begin
                    r_pendRd <= idExRt;
                    if (LOAD_LATENCY > 1) begin
                        r_bubbleCnt <= c_BUBBLE_INIT;
                        r_state     <= c_ST_LOAD_USE;
                    end
                end
            end
        end
    end

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stallCounter (
        .clk      (clk),
        .i_clearN (resetN),
        .i_en     (~w_ctrl.pcWrite),
        .o_count  (stallCount)
    );

    assign pcWrite    = w_ctrl.pcWrite;
    assign ifIdWrite  = w_ctrl.ifIdWrite;
    assign ifIdFlush  = w_ctrl.ifIdFlush;
    assign idExFlush  = w_ctrl.idExFlush;
    assign exMemStall = w_ctrl.exMemStall;

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed self-checking bench; three instances cover load
//               latencies 1, 2 and 3 (the first with a 4-bit stall counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       resetN;
    logic [4:0] ifIdRs, ifIdRt, idExRt;
    logic       ifIdUsesRt, idExMemRead, exMemMemRead, exMemMemWrite;
    logic       memReady, branchTaken;

    logic        aPc, aIfW, aIfF, aIdF, aMem;
    logic [3:0]  aCnt;
    logic        bPc, bIfW, bIfF, bIdF, bMem;
    logic [15:0] bCnt;
    logic        cPc, cIfW, cIfF, cIdF, cMem;
    logic [15:0] cCnt;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(4)) u_dutA (
        .clk(clk), .resetN(resetN), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
        .ifIdUsesRt(ifIdUsesRt), .idExRt(idExRt), .idExMemRead(idExMemRead),
        .exMemMemRead(exMemMemRead), .exMemMemWrite(exMemMemWrite),
        .memReady(memReady), .branchTaken(branchTaken), .pcWrite(aPc),
        .ifIdWrite(aIfW), .ifIdFlush(aIfF), .idExFlush(aIdF),
        .exMemStall(aMem), .stallCount(aCnt));

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .CNT_W(16)) u_dutB (
        .clk(clk), .resetN(resetN), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
        .ifIdUsesRt(ifIdUsesRt), .idExRt(idExRt), .idExMemRead(idExMemRead),
        .exMemMemRead(exMemMemRead), .exMemMemWrite(exMemMemWrite),
        .memReady(memReady), .branchTaken(branchTaken), .pcWrite(bPc),
        .ifIdWrite(bIfW), .ifIdFlush(bIfF), .idExFlush(bIdF),
        .exMemStall(bMem), .stallCount(bCnt));

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16)) u_dutC (
        .clk(clk), .resetN(resetN), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
        .ifIdUsesRt(ifIdUsesRt), .idExRt(idExRt), .idExMemRead(idExMemRead),
        .exMemMemRead(exMemMemRead), .exMemMemWrite(exMemMemWrite),
        .memReady(memReady), .branchTaken(branchTaken), .pcWrite(cPc),
        .ifIdWrite(cIfW), .ifIdFlush(cIfF), .idExFlush(cIdF),
        .exMemStall(cMem), .stallCount(cCnt));

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ifIdRs = '0; ifIdRt = '0; idExRt = '0; ifIdUsesRt = 1'b0;
        idExMemRead = 1'b0; exMemMemRead = 1'b0; exMemMemWrite = 1'b0;
        memReady = 1'b0; branchTaken = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        clearInputs();
        resetN = 1'b0;
        tick();
        tick();
        #1;
        checkVal("rst_pcWrite",    aPc,  0);
        checkVal("rst_ifIdWrite",  aIfW, 0);
        checkVal("rst_ifIdFlush",  aIfF, 1);
        checkVal("rst_idExFlush",  aIdF, 1);
        checkVal("rst_exMemStall", aMem, 0);
        resetN = 1'b1;
        #1;
        checkVal("rel_pcWrite",    aPc,  1);
        checkVal("rel_idExFlush",  aIdF, 0);
        checkVal("rel_stallCount", 32'(aCnt), 0);

        // Load-use via Rs, latency 1
        idExMemRead = 1'b1; idExRt = 5'd5; ifIdRs = 5'd5;
        #1;
        checkVal("lu1_pcWrite",   aPc,  0);
        checkVal("lu1_idExFlush", aIdF, 1);
        checkVal("lu1_ifIdWrite", aIfW, 0);
        tick();
        idExMemRead = 1'b0;
        #1;
        checkVal("lu1_release",    aPc, 1);
        checkVal("lu1_stallCount", 32'(aCnt), 1);

        // Load-use via Rt, latency 2
        doReset();
        idExMemRead = 1'b1; idExRt = 5'd5; ifIdRs = 5'd1; ifIdRt = 5'd5; ifIdUsesRt = 1'b1;
        #1;
        checkVal("lu2_stall0", bPc, 0);
        tick();
        idExMemRead = 1'b0;
        #1;
        checkVal("lu2_stall1",      bPc,  0);
        checkVal("lu2_stall1_flush", bIdF, 1);
        tick();
        checkVal("lu2_release",    bPc, 1);
        checkVal("lu2_stallCount", 32'(bCnt), 2);
        idExMemRead = 1'b1; ifIdUsesRt = 1'b0;
        #1;
        checkVal("lu2_noRt_pcWrite", bPc, 1);
        ifIdUsesRt = 1'b1; idExRt = 5'd0; ifIdRt = 5'd0;
        #1;
        checkVal("lu2_r0_pcWrite", bPc, 1);
        tick();
        checkVal("lu2_r0_count", 32'(bCnt), 2);

        // Memory wait: 3 cycles busy then ready
        doReset();
        exMemMemRead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal("mw_exMemStall", aMem, 1);
            checkVal("mw_pcWrite",    aPc,  0);
            checkVal("mw_idExFlush",  aIdF, 0);
            tick();
        end
        memReady = 1'b1;
        #1;
        checkVal("mw_release_pc",  aPc,  1);
        checkVal("mw_release_mem", aMem, 0);
        tick();
        exMemMemRead = 1'b0;
        checkVal("mw_stallCount", 32'(aCnt), 3);

        // Branch cancels a latency-3 load-use stall
        doReset();
        idExMemRead = 1'b1; idExRt = 5'd7; ifIdRs = 5'd7;
        #1;
        checkVal("br_stall0", cPc, 0);
        tick();
        idExMemRead = 1'b0;
        #1;
        checkVal("br_stall1", cPc, 0);
        tick();
        branchTaken = 1'b1;
        #1;
        checkVal("br_pcWrite",   cPc,  1);
        checkVal("br_ifIdFlush", cIfF, 1);
        checkVal("br_idExFlush", cIdF, 1);
        tick();
        branchTaken = 1'b0;
        #1;
        checkVal("br_after_pc",    cPc,  1);
        checkVal("br_after_flush", cIdF, 0);
        checkVal("br_stallCount",  32'(cCnt), 2);

        // Memory wait inside LOAD_USE resumes the remaining bubbles
        doReset();
        idExMemRead = 1'b1; idExRt = 5'd9; ifIdRs = 5'd9;
        tick();
        idExMemRead = 1'b0; exMemMemRead = 1'b1;
        #1;
        checkVal("mlu_memStall", cMem, 1);
        checkVal("mlu_noBubble", cIdF, 0);
        tick();
        memReady = 1'b1;
        #1;
        checkVal("mlu_resume_pc",   cPc,  0);
        checkVal("mlu_resume_mem",  cMem, 0);
        checkVal("mlu_resume_idEx", cIdF, 1);
        tick();
        exMemMemRead = 1'b0; memReady = 1'b0;
        #1;
        checkVal("mlu_last_bubble", cPc, 0);
        tick();
        checkVal("mlu_release", cPc, 1);

        // Saturation of 4-bit counter, then reset mid MEM_WAIT
        doReset();
        exMemMemRead = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        checkVal("sat_at15", 32'(aCnt), 15);
        tick();
        tick();
        checkVal("sat_hold", 32'(aCnt), 15);
        resetN = 1'b0;
        #1;
        checkVal("rstmid_pcWrite",    aPc,  0);
        checkVal("rstmid_exMemStall", aMem, 0);
        checkVal("rstmid_ifIdFlush",  aIfF, 1);
        tick();
        resetN = 1'b1; exMemMemRead = 1'b0;
        #1;
        checkVal("rstmid_count", 32'(aCnt), 0);
        checkVal("rstmid_pc",    aPc, 1);
        checkVal("rstmid_mem",   aMem, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

endmodule : tb_hazard_stall_unit
`default_nettype wire
